// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared types and parameter limits for the AER acknowledge buffer
package aer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    ACKED   = 2'd2,
    WAIT_LO = 2'd3
  } aer_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;
  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;

endpackage

// File: rtl/aer_ack_chan.sv
// rtl/aer_ack_chan.sv - one AER channel: req synchroniser, four-phase handshake FSM, delay counter
module aer_ack_chan
  import aer_pkg::*;
#(
  parameter int DLY_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             en,
  input  logic [DLY_W-1:0] dly,
  output logic             ack,
  output logic             ev,
  output logic             err,
  output logic             ev_nxt
);

  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              req_s;

  aer_state_t        state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic              ack_d, ev_d, err_d;

  assign req_s  = sync_q[STAGES-1];
  assign ev_nxt = ev_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
      ev      <= 1'b0;
      err     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], req};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= ack_d;
      ev      <= ev_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack;
    ev_d    = 1'b0;
    err_d   = 1'b0;
    // A disabled channel is parked silently, whatever phase it was in.
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            state_d = WAIT_HI;
            cnt_d   = dly;
          end
        end
        WAIT_HI: begin
          if (!req_s) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ACKED;
            ack_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ACKED: begin
          if (!req_s) begin
            state_d = WAIT_LO;
            cnt_d   = dly;
          end
        end
        WAIT_LO: begin
          if (req_s) begin
            state_d = ACKED;
            err_d   = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            ev_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aer_ack_buffer.sv
// rtl/aer_ack_buffer.sv - N_CH AER req/ack channels with a saturating completed-event counter
module aer_ack_buffer
  import aer_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DLY_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EVCNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH-1:0]    en,
  input  logic [DLY_W-1:0]   dly,
  output logic [N_CH-1:0]    ack,
  output logic [N_CH-1:0]    ev,
  output logic [N_CH-1:0]    err,
  output logic [EVCNT_W-1:0] ev_count,
  input  logic               clr_count
);

  localparam int PC_W  = $clog2(N_CH_MAX + N_CH_MIN);
  localparam int SUM_W = EVCNT_W + PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({EVCNT_W{1'b1}});

  logic [N_CH-1:0]  ev_nxt;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    aer_ack_chan #(
      .DLY_W       (DLY_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .req    (req[i]),
      .en     (en[i]),
      .dly    (dly),
      .ack    (ack[i]),
      .ev     (ev[i]),
      .err    (err[i]),
      .ev_nxt (ev_nxt[i])
    );
  end

  // Count the pulses being registered on this edge so ev_count moves with ev.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + PC_W'(ev_nxt[i]);
    end
    sum = SUM_W'(ev_count) + SUM_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      ev_count <= '0;
    end else if (sum > CNT_MAX) begin
      ev_count <= '1;
    end else begin
      ev_count <= sum[EVCNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_aer_ack_buffer.sv
// tb/tb_aer_ack_buffer.sv - directed and randomized checks of aer_ack_buffer against a deadline model
module tb_aer_ack_buffer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int S  = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clr_count;
  logic [N-1:0]   req, en;
  logic [DW-1:0]  dly;
  logic [N-1:0]   ack, ev, err;
  logic [CW-1:0]  ev_count;
  logic [N-1:0]   ack2, ev2, err2;
  logic [1:0]     ev_count2;

  aer_ack_buffer #(.N_CH(N), .DLY_W(DW), .SYNC_STAGES(S), .EVCNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .en(en), .dly(dly),
    .ack(ack), .ev(ev), .err(err), .ev_count(ev_count), .clr_count(clr_count)
  );

  aer_ack_buffer #(.N_CH(N), .DLY_W(DW), .SYNC_STAGES(S), .EVCNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .en(en), .dly(dly),
    .ack(ack2), .ev(ev2), .err(err2), .ev_count(ev_count2), .clr_count(clr_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference: req is seen S edges late; a wait entered at edge k finishes at edge k+dly+1.
  bit         pipe [N][S];
  int         phase [N];
  int         deadline [N];
  logic [N-1:0] m_ack, m_ev, m_err;
  int         m_cnt, m_cnt2, cyc;

  task automatic model_step();
    int evs;
    cyc++;
    m_ev  = '0;
    m_err = '0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        phase[c] = 0;
        for (int s = 0; s < S; s++) pipe[c][s] = 1'b0;
      end
      m_ack  = '0;
      m_cnt  = 0;
      m_cnt2 = 0;
      return;
    end
    for (int c = 0; c < N; c++) begin
      bit rs;
      rs = pipe[c][S-1];
      if (!en[c]) begin
        phase[c] = 0;
        m_ack[c] = 1'b0;
      end else begin
        case (phase[c])
          0: if (rs) begin phase[c] = 1; deadline[c] = cyc + int'(dly) + 1; end
          1: if (!rs) begin phase[c] = 0; m_err[c] = 1'b1; end
             else if (cyc == deadline[c]) begin phase[c] = 2; m_ack[c] = 1'b1; end
          2: if (!rs) begin phase[c] = 3; deadline[c] = cyc + int'(dly) + 1; end
          default: if (rs) begin phase[c] = 2; m_err[c] = 1'b1; end
             else if (cyc == deadline[c]) begin phase[c] = 0; m_ack[c] = 1'b0; m_ev[c] = 1'b1; end
        endcase
      end
      for (int s = S - 1; s > 0; s--) pipe[c][s] = pipe[c][s-1];
      pipe[c][0] = req[c];
    end
    evs = $countones(m_ev);
    if (clr_count) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      m_cnt  = (m_cnt + evs > 65535) ? 65535 : m_cnt + evs;
      m_cnt2 = (m_cnt2 + evs > 3) ? 3 : m_cnt2 + evs;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++; if (ack !== 4'b0) $display("FAIL reset_ack: got %b expected 0000", ack); else n_pass++;
    n_total++; if (ev !== 4'b0 || err !== 4'b0) $display("FAIL reset_pulses: got ev=%b err=%b expected 0", ev, err); else n_pass++;
    n_total++; if (ev_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", ev_count); else n_pass++;
    rst = 1'b0;
    en  = '1;
    tick();
  endtask

  task automatic test_single();
    dly = 8'd0;
    req[0] = 1'b1;
    repeat (3) tick();
    n_total++; if (ack[0] !== 1'b0) $display("FAIL single_early: got %b expected 0", ack[0]); else n_pass++;
    tick();
    n_total++; if (ack[0] !== 1'b1) $display("FAIL single_rise: got %b expected 1", ack[0]); else n_pass++;
    repeat (6) tick();
    req[0] = 1'b0;
    repeat (3) tick();
    n_total++; if (ack[0] !== 1'b1 || ev[0] !== 1'b0) $display("FAIL single_hold: got ack=%b ev=%b expected 1 0", ack[0], ev[0]); else n_pass++;
    tick();
    n_total++; if (ack[0] !== 1'b0 || ev[0] !== 1'b1) $display("FAIL single_fall: got ack=%b ev=%b expected 0 1", ack[0], ev[0]); else n_pass++;
    n_total++; if (ev_count !== 16'd1) $display("FAIL single_count: got %0d expected 1", ev_count); else n_pass++;
    tick();
    n_total++; if (ev[0] !== 1'b0) $display("FAIL single_ev_once: got %b expected 0", ev[0]); else n_pass++;
  endtask

  task automatic test_delay();
    int rise, fall;
    dly = 8'd5;
    req[1] = 1'b1;
    rise = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 3) dly = 8'd0;
      if (ack[1] === 1'b1 && rise < 0) rise = k;
    end
    n_total++; if (rise != 8) $display("FAIL delay_rise: got edge %0d expected 8", rise); else n_pass++;
    req[1] = 1'b0;
    fall = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack[1] === 1'b0 && fall < 0) fall = k;
    end
    n_total++; if (fall != 3) $display("FAIL delay_fall: got edge %0d expected 3", fall); else n_pass++;
    n_total++; if (ev_count !== 16'd2) $display("FAIL delay_count: got %0d expected 2", ev_count); else n_pass++;
  endtask

  task automatic test_max_delay();
    int rise;
    dly = 8'hFF;
    req[1] = 1'b1;
    rise = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (ack[1] === 1'b1 && rise < 0) rise = k;
    end
    n_total++; if (rise != 258) $display("FAIL max_delay_rise: got edge %0d expected 258", rise); else n_pass++;
    dly = 8'd0;
    req[1] = 1'b0;
    repeat (8) tick();
    n_total++; if (ack[1] !== 1'b0 || ev_count !== 16'd3) $display("FAIL max_delay_done: got ack=%b count=%0d expected 0 3", ack[1], ev_count); else n_pass++;
  endtask

  task automatic test_violation();
    int errs, seen, base, held;
    base = int'(ev_count);
    dly = 8'd10;
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    errs = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (err[2] === 1'b1) errs++;
      if (ack[2] === 1'b1) seen = 1;
    end
    n_total++; if (errs != 1) $display("FAIL viol_hi_err: got %0d pulses expected 1", errs); else n_pass++;
    n_total++; if (seen != 0) $display("FAIL viol_hi_ack: got ack seen=%0d expected 0", seen); else n_pass++;
    dly = 8'd6;
    req[2] = 1'b1;
    for (int k = 0; k < 20 && ack[2] !== 1'b1; k++) tick();
    n_total++; if (ack[2] !== 1'b1) $display("FAIL viol_lo_setup: got %b expected 1", ack[2]); else n_pass++;
    req[2] = 1'b0;
    repeat (3) tick();
    req[2] = 1'b1;
    errs = 0; held = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (err[2] === 1'b1) errs++;
      if (ack[2] !== 1'b1) held = 0;
    end
    n_total++; if (errs != 1) $display("FAIL viol_lo_err: got %0d pulses expected 1", errs); else n_pass++;
    n_total++; if (held != 1) $display("FAIL viol_lo_ack: got held=%0d expected 1", held); else n_pass++;
    req[2] = 1'b0;
    repeat (15) tick();
    n_total++; if (int'(ev_count) != base + 1) $display("FAIL viol_count: got %0d expected %0d", ev_count, base + 1); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int full, any, base;
    base = int'(ev_count);
    dly = 8'd2;
    req = '1;
    repeat (10) tick();
    req = '0;
    full = 0; any = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ev === 4'b1111) full++;
      if (ev !== 4'b0000) any++;
    end
    n_total++; if (full != 1 || any != 1) $display("FAIL simul_ev: got full=%0d any=%0d expected 1 1", full, any); else n_pass++;
    n_total++; if (int'(ev_count) != base + 4) $display("FAIL simul_count: got %0d expected %0d", ev_count, base + 4); else n_pass++;
    n_total++; if (ev_count2 !== 2'd3) $display("FAIL simul_saturate: got %0d expected 3", ev_count2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int errs;
    dly = 8'd0;
    req[3] = 1'b1;
    repeat (6) tick();
    n_total++; if (ack[3] !== 1'b1) $display("FAIL rstmid_setup: got %b expected 1", ack[3]); else n_pass++;
    rst = 1'b1;
    req[3] = 1'b0;
    tick();
    n_total++; if (ack[3] !== 1'b0 || err !== 4'b0) $display("FAIL rstmid_drop: got ack=%b err=%b expected 0 0000", ack[3], err); else n_pass++;
    n_total++; if (ev_count !== 16'd0 || ev_count2 !== 2'd0) $display("FAIL rstmid_count: got %0d/%0d expected 0", ev_count, ev_count2); else n_pass++;
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (err !== 4'b0 || ack !== 4'b0) errs++;
    end
    n_total++; if (errs != 0) $display("FAIL rstmid_after: got %0d bad cycles expected 0", errs); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int pulses;
    dly = 8'd10;
    req[3] = 1'b1;
    repeat (4) tick();
    en[3] = 1'b0;
    tick();
    n_total++; if (ack[3] !== 1'b0 || ev[3] !== 1'b0 || err[3] !== 1'b0) $display("FAIL en_drop: got ack=%b ev=%b err=%b expected 0 0 0", ack[3], ev[3], err[3]); else n_pass++;
    req[3] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) en[3] = 1'b1;
      tick();
      if (ev[3] === 1'b1 || err[3] === 1'b1 || ack[3] === 1'b1) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL en_quiet: got %0d active cycles expected 0", pulses); else n_pass++;
  endtask

  task automatic test_clear();
    dly = 8'd0;
    req[0] = 1'b1; repeat (6) tick();
    req[0] = 1'b0; repeat (6) tick();
    n_total++; if (ev_count !== 16'd1) $display("FAIL clear_setup: got %0d expected 1", ev_count); else n_pass++;
    req[0] = 1'b1; repeat (6) tick();
    req[0] = 1'b0; repeat (3) tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_total++; if (ev[0] !== 1'b1 || ev_count !== 16'd0) $display("FAIL clear_same_cycle: got ev=%b count=%0d expected 1 0", ev[0], ev_count); else n_pass++;
    tick();
    n_total++; if (ev_count !== 16'd0) $display("FAIL clear_lost: got %0d expected 0", ev_count); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) req[c] = ~req[c];
        if ($urandom_range(0, 149) == 0) en[c] = ~en[c];
      end
      if ($urandom_range(0, 31) == 0) dly = DW'($urandom_range(0, 5));
      clr_count = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
      n_total++; if (ack !== m_ack) $display("FAIL rand_ack: cycle %0d got %b expected %b", cyc, ack, m_ack); else n_pass++;
      n_total++; if (ev !== m_ev) $display("FAIL rand_ev: cycle %0d got %b expected %b", cyc, ev, m_ev); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL rand_err: cycle %0d got %b expected %b", cyc, err, m_err); else n_pass++;
      n_total++; if (ev_count !== CW'(m_cnt)) $display("FAIL rand_count: cycle %0d got %0d expected %0d", cyc, ev_count, m_cnt); else n_pass++;
      n_total++; if (ev_count2 !== 2'(m_cnt2)) $display("FAIL rand_sat: cycle %0d got %0d expected %0d", cyc, ev_count2, m_cnt2); else n_pass++;
    end
    rst = 1'b0;
    clr_count = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_count = 1'b0; req = '0; en = '0; dly = '0;
    cyc = 0; m_ack = '0; m_ev = '0; m_err = '0; m_cnt = 0; m_cnt2 = 0;
    for (int c = 0; c < N; c++) begin
      phase[c] = 0;
      deadline[c] = 0;
      for (int s = 0; s < S; s++) pipe[c][s] = 1'b0;
    end
    test_reset();
    test_single();
    test_delay();
    test_max_delay();
    test_violation();
    test_simultaneous();
    test_reset_mid();
    test_enable_drop();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aer_ack_buffer.md
Name: aer_ack_buffer

Overview:
- Multi-channel, synchronous successor to the fixed-delay AER acknowledge buffer.
- For each AER channel, it synchronises the asynchronous request, then runs a four-phase req/ack handshake with a runtime-programmable acknowledge delay in clock cycles.
- Flags protocol violations and keeps a saturating count of completed events.
- Sits between the off-chip AER sender pins and the address-capture logic, one instance per AER bus group.

Parameters:
- N_CH, 4, number of independent req/ack channels (1..32)
- DLY_W, 8, width of the programmable delay value
- SYNC_STAGES, 2, synchroniser flops on each req input (2..3)
- EVCNT_W, 16, width of the completed-event counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  N_CH  raw asynchronous AER request per channel
- en  input  N_CH  per-channel enable
- dly  input  DLY_W  acknowledge delay in cycles, shared by all channels
- ack  output  N_CH  registered acknowledge per channel
- ev  output  N_CH  one-cycle pulse per channel when a handshake completes
- err  output  N_CH  one-cycle pulse per channel on a protocol violation
- ev_count  output  EVCNT_W  saturating total of completed handshakes
- clr_count  input  1  synchronous clear of ev_count

Behaviour:
- Reset: at a clk edge with rst=1, the following all go to 0 and stay 0 while rst=1:
  - ack, ev, err, ev_count
  - all synchroniser flops
  - all per-channel counters
  - every channel FSM goes to IDLE
- Reset mid-handshake drops ack on that same edge. No err is raised.
- Synchroniser: req_s[i] is req[i] after SYNC_STAGES flops. The FSM sees only req_s.
- Per-channel FSM states: IDLE, WAIT_HI, ACKED, WAIT_LO. All outputs are registered.
- IDLE, ack=0:
  - req_s=1 and en=1 -> WAIT_HI, cnt <= dly.
- WAIT_HI, ack=0:
  - req_s=0 -> IDLE, err pulse (request withdrawn before ack).
  - else cnt==0 -> ACKED, ack <= 1.
  - else cnt <= cnt-1.
- ACKED, ack=1:
  - req_s=0 -> WAIT_LO, cnt <= dly.
- WAIT_LO, ack=1:
  - req_s=1 -> ACKED, err pulse (re-request before ack release); ack stays 1.
  - else cnt==0 -> IDLE, ack <= 0, ev pulse.
  - else cnt <= cnt-1.
- Latency:
  - Raw req rise captured at edge j -> ack high after edge j+SYNC_STAGES+dly+1.
  - Example: dly=0 with SYNC_STAGES=2 gives 3 cycles.
  - The falling phase is symmetric.
- dly is sampled only on entry to WAIT_HI or WAIT_LO. Changing dly mid-wait does not affect the wait in progress.
- en[i]=0 in any state:
  - next edge -> IDLE, ack=0, cnt=0.
  - No ev or err pulse.
  - The en check has priority over all FSM transitions.
- ev_count:
  - Each edge adds popcount(ev) of the pulses registered that cycle; this may exceed 1 when channels complete together.
  - Saturates at 2^EVCNT_W-1 and never wraps.
- clr_count=1 sets ev_count to 0 on that edge. Clear has priority over the increment in the same cycle, so those events are lost.
- Counter width: the internal cnt is DLY_W bits. dly = 2^DLY_W-1 is legal and gives the maximum wait with no overflow.

Decomposition:
- Shared package aer_pkg holds:
  - the state enum (IDLE, WAIT_HI, ACKED, WAIT_LO)
  - min/max limits for SYNC_STAGES and N_CH
- Sub-module aer_ack_chan contains one channel: synchroniser, FSM, delay counter, and ev/err generation. It is instantiated N_CH times by generate.
- The top level holds only the popcount and the saturating ev_count.

Test Plan:
- Single handshake, N_CH=4, dly=0, ch0: raise req[0] at edge 10.
  - ack[0]=1 after edge 13.
  - Drop req at 20 -> ack[0]=0 after edge 23.
  - ev[0] pulses once, at edge 23.
  - ev_count=1.
- Delay programming, dly=5, ch1: ack rises 8 edges after the req rise.
  - Change dly to 0 during WAIT_HI -> rise still at 8.
  - Next phase uses 0.
- Violations:
  - ch2 req pulse of 1 cycle with dly=10 -> err[2] pulse, ack[2] never rises, FSM returns to IDLE.
  - ch2 re-raising req during WAIT_LO -> err[2] pulse, ack stays 1.
- Simultaneous completion, dly=2: all 4 channels complete on the same edge.
  - ev=4'b1111 for one cycle.
  - ev_count increments by 4.
  - With EVCNT_W=2 preloaded to 3 -> stays at 3.
- Reset/enable mid-handshake, ch3 in ACKED:
  - Assert rst for 1 cycle -> ack[3]=0 on that edge, no err, ev_count=0.
  - Separately, drop en[3] in WAIT_HI -> IDLE next edge, no pulses.
- clr_count with a same-cycle ev pulse -> ev_count=0.
